i2s_tx: RTL

Stereo I2S transmitter for the Pmod I2S2 DAC (CS4344) on the 100 MHz Nexys3 clock. It accepts 24-bit samples from the filter path on a valid strobe and buffers them in a holding register. At each frame boundary it serializes the buffered pair onto MCLK/LRCK/SCLK/SDOUT. It generates all DAC clocks from a single free-running divider and emits a per-frame sample request, which upstream blocks use as their sample-rate tick.

---
 rtl/i2s_pkg.sv | 32 +++
 rtl/i2s_clkgen.sv | 38 +++
 rtl/i2s_tx.sv | 108 ++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Shared constants, the stereo sample type and the slot-to-bit mapping for the I2S
// transmit path. The receiver for the ADC path uses the same package.
package i2s_pkg;

  localparam int SMPL_W   = 24;
  localparam int CNT_W    = 10;
  localparam int MCLK_BIT = 1;
  localparam int SCLK_BIT = 3;
  localparam int LRCK_BIT = 9;
  localparam int SLOT_MSB = 1;
  localparam int SLOT_LSB = 24;
  localparam int SLOT_LO  = 4;
  localparam int SLOT_W   = 5;

  typedef struct packed {
    logic [SMPL_W-1:0] l;
    logic [SMPL_W-1:0] r;
  } stereo_t;

  // Slot 0 is the one-SCLK I2S delay. Slots SLOT_MSB..SLOT_LSB carry MSB..LSB.
  // Every other slot is zero.
  function automatic logic slot_bit(input logic [SMPL_W-1:0] shift,
                                    input logic [SLOT_W-1:0] slot);
    logic b;
    b = 1'b0;
    for (int i = 0; i < SMPL_W; i++) begin
      if (int'(slot) == SLOT_LSB - i) b = shift[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// Free-running 10-bit frame divider. It produces MCLK, SCLK and LRCK, the frame
// boundary strobes, and the slot and channel of the next cycle. i2s_rx reuses it.
module i2s_clkgen
  import i2s_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic              mclk_o,
  output logic              sclk_o,
  output logic              lrck_o,
  output logic              boundary_o,
  output logic              boundary_nxt_o,
  output logic              bit_edge_o,
  output logic [SLOT_W-1:0] slot_nxt_o,
  output logic              lr_nxt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign cnt_d = cnt_q + 1'b1;

  // NOTE: sequential state always uses <=, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign mclk_o         = cnt_q[MCLK_BIT];
  assign sclk_o         = cnt_q[SCLK_BIT];
  assign lrck_o         = cnt_q[LRCK_BIT];
  assign boundary_o     = &cnt_q;
  assign boundary_nxt_o = &cnt_d;
  assign bit_edge_o     = &cnt_q[SLOT_LO-1:0];
  assign slot_nxt_o     = cnt_d[SLOT_LO +: SLOT_W];
  assign lr_nxt_o       = cnt_d[LRCK_BIT];

endmodule

// File: rtl/i2s_tx.sv
// Stereo I2S transmitter for the CS4344. On a frame with no new sample it repeats the
// last sample, or sends zeros when I2S_TX_UNDERRUN_MUTE_EN is defined.
module i2s_tx
  import i2s_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [SMPL_W-1:0] din_l,
  input  logic [SMPL_W-1:0] din_r,
  input  logic              din_valid,
  output logic              sample_req,
  output logic              mclk,
  output logic              lrck,
  output logic              sclk,
  output logic              sdout,
  output logic              ovf,
  output logic              unf
);

  logic              boundary;
  logic              boundary_nxt;
  logic              bit_edge;
  logic              lr_nxt;
  logic [SLOT_W-1:0] slot_nxt;

  i2s_clkgen u_clkgen (
    .clk            (clk),
    .rst            (rst),
    .mclk_o         (mclk),
    .sclk_o         (sclk),
    .lrck_o         (lrck),
    .boundary_o     (boundary),
    .boundary_nxt_o (boundary_nxt),
    .bit_edge_o     (bit_edge),
    .slot_nxt_o     (slot_nxt),
    .lr_nxt_o       (lr_nxt)
  );

  stereo_t hold_q, hold_d;
  stereo_t shift_q, shift_d;
  logic    fresh_q, fresh_d;
  logic    ovf_q, ovf_d;
  logic    unf_q, unf_d;
  logic    sdout_q, sdout_d;
  logic    req_q, req_d;

  // NOTE: every signal gets its default first, so no path through this block infers a latch.
  always_comb begin
    hold_d  = hold_q;
    shift_d = shift_q;
    fresh_d = fresh_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    sdout_d = sdout_q;
    req_d   = boundary_nxt;

    if (boundary) begin
      fresh_d = 1'b0;
      if (fresh_q) begin
        shift_d = hold_q;
      end else begin
        unf_d = 1'b1;
`ifdef I2S_TX_UNDERRUN_MUTE_EN
        shift_d = '0;
`else
        shift_d = hold_q;
`endif
      end
    end

    // A strobe on the boundary cycle is placed after the boundary clear, so it stays fresh
    // for the next frame. It does not count as an overrun.
    if (din_valid) begin
      hold_d.l = din_l;
      hold_d.r = din_r;
      fresh_d  = 1'b1;
      if (fresh_q && !boundary) ovf_d = 1'b1;
    end

    if (bit_edge) sdout_d = slot_bit(lr_nxt ? shift_q.r : shift_q.l, slot_nxt);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_q  <= '0;
      shift_q <= '0;
      fresh_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      sdout_q <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      shift_q <= shift_d;
      fresh_q <= fresh_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      sdout_q <= sdout_d;
      req_q   <= req_d;
    end
  end

  assign sample_req = req_q;
  assign sdout      = sdout_q;
  assign ovf        = ovf_q;
  assign unf        = unf_q;

endmodule
